de_pipe_reg: RTL and testbench
==============================

DE_PIPE_REG -- requirements
Module: de_pipe_reg

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-003 The block SHALL have port stall_D, input, 1 bit: hazard-unit stall; inserts a bubble into E.
REQ-004 The block SHALL have port flush_D, input, 1 bit: squash the instruction currently in D.
REQ-005 The block SHALL have ports PC_D and Instr_D, input, 32 bits each: D-stage PC and instruction word.
REQ-006 The block SHALL have ports rs_D and rt_D, input, 5 bits each: D-stage source register numbers.
REQ-007 The block SHALL have ports RD1_D and RD2_D, input, 32 bits each: raw register-file read data.
REQ-008 The block SHALL have ports RFWr_M (1 bit), RegWrite_M (5 bits) and FwdData_M (32 bits), all inputs: M-stage pending write.
REQ-009 The block SHALL have ports RFWr_W (1 bit), RegWrite_W (5 bits) and Result_W (32 bits), all inputs: W-stage write, the same values that feed the register file.
REQ-010 The block SHALL have ports PC_E and Instr_E, output, 32 bits each: registered PC and instruction.
REQ-011 The block SHALL have ports RS_E and RT_E, output, 32 bits each: registered, forwarding-corrected operands.
REQ-012 The block SHALL have ports rs_E and rt_E, output, 5 bits each: registered source register numbers.
REQ-013 The block SHALL have port valid_E, output, 1 bit: 1 = E holds a real instruction; 0 = bubble.
REQ-014 The block SHALL have port bubble_cnt, output, 16 bits: saturating count of bubbles inserted.

Function
REQ-015 The block SHALL select the D operand combinationally, in priority order:
  - M forward: RFWr_M=1, RegWrite_M=src, src≠0;
  - else W forward: RFWr_W=1, RegWrite_W=src, src≠0;
  - else RD1_D/RD2_D.
REQ-016 The block SHALL make any operand with source register 0 read as 32'h0 regardless of forwarding inputs.
REQ-017 The block SHALL, on each rising edge with reset=1, stall_D=0 and flush_D=0, capture the D-stage values into the E outputs and set valid_E=1 (latency 1 cycle).
REQ-018 The block SHALL, on an edge with stall_D=1 or flush_D=1, load a bubble: all E data outputs 0 and valid_E=0.
REQ-019 The block SHALL give stall_D and flush_D identical effect when both are asserted in the same cycle (one bubble).
REQ-020 The block SHALL increment bubble_cnt by 1 on each bubble edge and hold it at 16'hFFFF once there (no wrap).
REQ-021 The block SHALL apply the W forward on the same edge as the register-file write, so that an E operand never holds the stale pre-write value.

Reset
REQ-022 The block SHALL, on an edge with reset=0, clear PC_E, Instr_E, RS_E, RT_E, rs_E, rt_E, valid_E and bubble_cnt to 0, overriding stall_D and flush_D.
REQ-023 The block SHALL make the first capture of real D data on the first edge after reset returns to 1.
REQ-024 The block SHALL, when reset is asserted mid-stream, discard any in-flight instruction without counting a bubble.

Configuration
REQ-025 The block SHALL use macro DE_FWD_EN to control forwarding.
  - Defined: forwarding logic per REQ-015 and REQ-021 is compiled in.
  - Undefined: RS_E/RT_E capture RD1_D/RD2_D directly (zero rule REQ-016 still applies), M/W forwarding inputs are ignored, and the hazard unit must stall for all RAW hazards.

Structure
REQ-026 The block SHALL take from the shared package (mips_pkg): the 5-bit register-number typedef, the 32-bit word typedef, the bubble-word constant (32'h0) and the counter width constant (16).
REQ-027 The block SHALL place the forwarding selector in a sub-module named fwd_sel, instantiated twice (rs, rt); everything else is inline.

Verification
REQ-028 The bench SHALL drive reset=0 for 2 cycles with stall_D=1, then check all outputs = 0 and bubble_cnt = 0.
REQ-029 The bench SHALL drive rs_D=8, RD1_D=32'h11, RFWr_M=1, RegWrite_M=8, FwdData_M=32'hAA, RFWr_W=1, RegWrite_W=8, Result_W=32'hBB, then check after 1 edge: RS_E=32'hAA, valid_E=1.
REQ-030 The bench SHALL drive rt_D=0, RFWr_M=1, RegWrite_M=0, FwdData_M=32'hFF, then check after 1 edge: RT_E=32'h0.
REQ-031 The bench SHALL drive PC_D=32'h3000 and Instr_D=32'h8C080004 with stall_D=1 for 3 cycles, then 0, then check:
  - stalled edges: valid_E=0 and PC_E=0;
  - bubble_cnt=3;
  - next edge: PC_E=32'h3000.
REQ-032 The bench SHALL preload bubble_cnt at 16'hFFFE via 65534 stall cycles, then apply 3 more stalls, and check bubble_cnt=16'hFFFF.
REQ-033 The bench SHALL compile without DE_FWD_EN and repeat the REQ-029 stimulus, then check RS_E=32'h11.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants for the D->E boundary.
// DE_FWD_EN (optional): enables M/W operand forwarding in fwd_sel.
package mips_pkg;

   typedef logic [4:0]  reg_t;
   typedef logic [31:0] word_t;

   localparam word_t BUBBLE_WORD = 32'h0;
   localparam int    CNT_W       = 16;

   typedef struct packed {
      word_t pc;
      word_t instr;
      word_t rs_v;
      word_t rt_v;
      reg_t  rs;
      reg_t  rt;
      logic  valid;
   } id_ex_t;

endpackage

// File: rtl/de_pipe_reg_fwd_sel.sv
// Operand selector: register 0 reads zero, then M, then W, then regfile.
// DE_FWD_EN undefined: forwarding inputs are ignored.
module fwd_sel
   import mips_pkg::*;
(
   input  reg_t  i_src,
   input  word_t i_rd,
   input  logic  i_m_wr,
   input  reg_t  i_m_reg,
   input  word_t i_m_data,
   input  logic  i_w_wr,
   input  reg_t  i_w_reg,
   input  word_t i_w_data,
   output word_t o_opnd
);

   logic w_zero;

   assign w_zero = (i_src == 5'd0);

`ifdef DE_FWD_EN
   logic w_m_hit;
   logic w_w_hit;

   assign w_m_hit = !w_zero && i_m_wr && (i_m_reg == i_src);
   assign w_w_hit = !w_zero && !w_m_hit && i_w_wr && (i_w_reg == i_src);

   always_comb begin
      o_opnd = i_rd;
      unique case (1'b1)
         w_zero:  o_opnd = BUBBLE_WORD;
         w_m_hit: o_opnd = i_m_data;
         w_w_hit: o_opnd = i_w_data;
         default: o_opnd = i_rd;
      endcase
   end
`else
   logic w_unused;

   assign w_unused = ^{i_m_wr, i_m_reg, i_m_data,
                       i_w_wr, i_w_reg, i_w_data};

   assign o_opnd = w_zero ? BUBBLE_WORD : i_rd;
`endif

endmodule

// File: rtl/de_pipe_reg.sv
// D->E pipeline register with bubble insertion and saturating bubble count.
// DE_FWD_EN: compiles in M/W forwarding of the captured operands.
module de_pipe_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_D,
   input  logic        flush_D,
   input  word_t       PC_D,
   input  word_t       Instr_D,
   input  reg_t        rs_D,
   input  reg_t        rt_D,
   input  word_t       RD1_D,
   input  word_t       RD2_D,
   input  logic        RFWr_M,
   input  reg_t        RegWrite_M,
   input  word_t       FwdData_M,
   input  logic        RFWr_W,
   input  reg_t        RegWrite_W,
   input  word_t       Result_W,
   output word_t       PC_E,
   output word_t       Instr_E,
   output word_t       RS_E,
   output word_t       RT_E,
   output reg_t        rs_E,
   output reg_t        rt_E,
   output logic        valid_E,
   output logic [15:0] bubble_cnt
);

   word_t            w_rs_v;
   word_t            w_rt_v;
   logic             w_bubble;
   id_ex_t           r_e;
   logic [CNT_W-1:0] r_cnt;

   fwd_sel u_fwd_rs (
      .i_src    (rs_D),
      .i_rd     (RD1_D),
      .i_m_wr   (RFWr_M),
      .i_m_reg  (RegWrite_M),
      .i_m_data (FwdData_M),
      .i_w_wr   (RFWr_W),
      .i_w_reg  (RegWrite_W),
      .i_w_data (Result_W),
      .o_opnd   (w_rs_v)
   );

   fwd_sel u_fwd_rt (
      .i_src    (rt_D),
      .i_rd     (RD2_D),
      .i_m_wr   (RFWr_M),
      .i_m_reg  (RegWrite_M),
      .i_m_data (FwdData_M),
      .i_w_wr   (RFWr_W),
      .i_w_reg  (RegWrite_W),
      .i_w_data (Result_W),
      .o_opnd   (w_rt_v)
   );

   assign w_bubble = stall_D | flush_D;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_e   <= '0;
         r_cnt <= '0;
      end else if (w_bubble) begin
         r_e.pc    <= BUBBLE_WORD;
         r_e.instr <= BUBBLE_WORD;
         r_e.rs_v  <= BUBBLE_WORD;
         r_e.rt_v  <= BUBBLE_WORD;
         r_e.rs    <= '0;
         r_e.rt    <= '0;
         r_e.valid <= 1'b0;
         if (r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
      end else begin
         r_e.pc    <= PC_D;
         r_e.instr <= Instr_D;
         r_e.rs_v  <= w_rs_v;
         r_e.rt_v  <= w_rt_v;
         r_e.rs    <= rs_D;
         r_e.rt    <= rt_D;
         r_e.valid <= 1'b1;
      end
   end

   assign PC_E       = r_e.pc;
   assign Instr_E    = r_e.instr;
   assign RS_E       = r_e.rs_v;
   assign RT_E       = r_e.rt_v;
   assign rs_E       = r_e.rs;
   assign rt_E       = r_e.rt;
   assign valid_E    = r_e.valid;
   assign bubble_cnt = r_cnt;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Scoreboard bench for de_pipe_reg: driver pushes model results, monitor pops.
// Expectations follow DE_FWD_EN the same way the design build does.
module tb_de_pipe_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall_D = 1'b0;
   logic        flush_D = 1'b0;
   logic [31:0] PC_D = '0;
   logic [31:0] Instr_D = '0;
   logic [4:0]  rs_D = '0;
   logic [4:0]  rt_D = '0;
   logic [31:0] RD1_D = '0;
   logic [31:0] RD2_D = '0;
   logic        RFWr_M = 1'b0;
   logic [4:0]  RegWrite_M = '0;
   logic [31:0] FwdData_M = '0;
   logic        RFWr_W = 1'b0;
   logic [4:0]  RegWrite_W = '0;
   logic [31:0] Result_W = '0;
   logic [31:0] PC_E;
   logic [31:0] Instr_E;
   logic [31:0] RS_E;
   logic [31:0] RT_E;
   logic [4:0]  rs_E;
   logic [4:0]  rt_E;
   logic        valid_E;
   logic [15:0] bubble_cnt;

   de_pipe_reg dut (
      .clk        (clk),
      .reset      (reset),
      .stall_D    (stall_D),
      .flush_D    (flush_D),
      .PC_D       (PC_D),
      .Instr_D    (Instr_D),
      .rs_D       (rs_D),
      .rt_D       (rt_D),
      .RD1_D      (RD1_D),
      .RD2_D      (RD2_D),
      .RFWr_M     (RFWr_M),
      .RegWrite_M (RegWrite_M),
      .FwdData_M  (FwdData_M),
      .RFWr_W     (RFWr_W),
      .RegWrite_W (RegWrite_W),
      .Result_W   (Result_W),
      .PC_E       (PC_E),
      .Instr_E    (Instr_E),
      .RS_E       (RS_E),
      .RT_E       (RT_E),
      .rs_E       (rs_E),
      .rt_E       (rt_E),
      .valid_E    (valid_E),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rs_v;
      logic [31:0] rt_v;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        valid;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   m_cnt = 0;
   bit   started = 0;

   function automatic logic [31:0] opnd(input logic [4:0] src,
                                        input logic [31:0] rd);
      if (src == 5'd0) return 32'h0;
`ifdef DE_FWD_EN
      if (RFWr_M && RegWrite_M == src) return FwdData_M;
      if (RFWr_W && RegWrite_W == src) return Result_W;
`endif
      return rd;
   endfunction

   task automatic step(input string nm);
      exp_t e;
      e.name = nm;
      if (!reset) begin
         e.pc = 0; e.instr = 0; e.rs_v = 0; e.rt_v = 0;
         e.rs = 0; e.rt = 0; e.valid = 0;
         m_cnt = 0;
      end else if (stall_D || flush_D) begin
         e.pc = 0; e.instr = 0; e.rs_v = 0; e.rt_v = 0;
         e.rs = 0; e.rt = 0; e.valid = 0;
         m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      end else begin
         e.pc = PC_D; e.instr = Instr_D;
         e.rs_v = opnd(rs_D, RD1_D);
         e.rt_v = opnd(rt_D, RD2_D);
         e.rs = rs_D; e.rt = rt_D; e.valid = 1'b1;
      end
      e.cnt = m_cnt[15:0];
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (started) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL monitor got output with no expectation");
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({PC_E, Instr_E, RS_E, RT_E, rs_E, rt_E, valid_E,
                 bubble_cnt} !==
                {e.pc, e.instr, e.rs_v, e.rt_v, e.rs, e.rt, e.valid,
                 e.cnt}) begin
               errors++;
               $display("FAIL %s got pc=%h in=%h rs=%h rt=%h %0d %0d v=%b c=%h want pc=%h in=%h rs=%h rt=%h %0d %0d v=%b c=%h",
                        e.name, PC_E, Instr_E, RS_E, RT_E, rs_E, rt_E,
                        valid_E, bubble_cnt, e.pc, e.instr, e.rs_v,
                        e.rt_v, e.rs, e.rt, e.valid, e.cnt);
            end
         end
      end
   end

   initial begin
      started = 1;
      reset = 0; stall_D = 1;
      step("reset0");
      step("reset1");
      chk("reset_valid", {31'h0, valid_E}, 32'h0);
      chk("reset_pc", PC_E, 32'h0);
      chk("reset_cnt", {16'h0, bubble_cnt}, 32'h0);

      reset = 1; stall_D = 0;
      PC_D = 32'h100; Instr_D = 32'h01095020;
      rs_D = 8; RD1_D = 32'h11; rt_D = 9; RD2_D = 32'h22;
      RFWr_M = 1; RegWrite_M = 8; FwdData_M = 32'hAA;
      RFWr_W = 1; RegWrite_W = 8; Result_W = 32'hBB;
      step("fwd_m_over_w");
`ifdef DE_FWD_EN
      chk("fwd_rs_m", RS_E, 32'hAA);
`else
      chk("nofwd_rs", RS_E, 32'h11);
`endif
      chk("fwd_valid", {31'h0, valid_E}, 32'h1);

      rt_D = 0; RD2_D = 32'h55; RegWrite_M = 0; FwdData_M = 32'hFF;
      RegWrite_W = 0;
      step("zero_reg");
      chk("zero_rt", RT_E, 32'h0);

      reset = 0;
      step("reset_mid");
      reset = 1;
      PC_D = 32'h3000; Instr_D = 32'h8C080004; stall_D = 1;
      for (int i = 0; i < 3; i++) begin
         step("stall3");
         chk("stall_pc", PC_E, 32'h0);
         chk("stall_valid", {31'h0, valid_E}, 32'h0);
      end
      chk("stall_cnt3", {16'h0, bubble_cnt}, 32'h3);
      stall_D = 0;
      step("release");
      chk("release_pc", PC_E, 32'h3000);

      flush_D = 1; stall_D = 1;
      step("stall_and_flush");
      chk("both_one_bubble", {16'h0, bubble_cnt}, 32'h4);
      stall_D = 0;
      step("flush_only");
      flush_D = 0;

      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 39) != 0);
         stall_D    = ($urandom_range(0, 3) == 0);
         flush_D    = ($urandom_range(0, 7) == 0);
         PC_D       = $urandom;
         Instr_D    = $urandom;
         rs_D       = 5'($urandom_range(0, 4));
         rt_D       = 5'($urandom_range(0, 4));
         RD1_D      = $urandom;
         RD2_D      = $urandom;
         RFWr_M     = 1'($urandom);
         RegWrite_M = 5'($urandom_range(0, 4));
         FwdData_M  = $urandom;
         RFWr_W     = 1'($urandom);
         RegWrite_W = 5'($urandom_range(0, 4));
         Result_W   = $urandom;
         step("random");
      end

      reset = 0; stall_D = 0; flush_D = 0;
      step("reset_sat");
      reset = 1; stall_D = 1;
      for (int i = 0; i < 65534; i++) step("preload");
      chk("cnt_fffe", {16'h0, bubble_cnt}, 32'hFFFE);
      for (int i = 0; i < 3; i++) step("saturate");
      chk("cnt_ffff", {16'h0, bubble_cnt}, 32'hFFFF);
      stall_D = 0;
      step("sat_release");
      chk("cnt_hold", {16'h0, bubble_cnt}, 32'hFFFF);

      started = 0;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
